// File: rtl/parallel_bus_pollable_memory.sv
// parallel_bus_pollable_memory
// Handshaken host-bus slave fronting a pollable block RAM with status and burst access.
module parallel_bus_pollable_memory #(
    parameter int BUS_WIDTH          = 8,
    parameter int ADDRESS_WORDS      = 2,
    parameter int DATA_WORDS         = 4,
    parameter int ADDRESS_DEPTH_LOG2 = 8,
    parameter bit AUTO_INCREMENT     = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [BUS_WIDTH-1:0] bus_in,
    output logic [BUS_WIDTH-1:0] bus_out,
    output logic                 bus_oe,
    input  logic                 read,
    input  logic                 register_select,
    input  logic                 enable,
    output logic                 ack,
    output logic                 write_strobe,
    output logic [BUS_WIDTH-1:0] write_count
);

    localparam int ADDR_W = BUS_WIDTH * ADDRESS_WORDS;
    localparam int MEM_W  = BUS_WIDTH * DATA_WORDS;
    localparam int DEPTH  = 1 << ADDRESS_DEPTH_LOG2;
    localparam int IDX_W  = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int SYNC_W = BUS_WIDTH + 3;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WORDS - 1);
    localparam logic [ADDR_W-1:0] LO_MASK  =
        {ADDR_W{1'b1}} >> (ADDR_W - ADDRESS_DEPTH_LOG2);

    // ack is state bit 1, so it comes straight off a flop with no decode glitch
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACT  = 2'b11,
        S_HOLD = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_W-1:0]    sync_1;
    logic [SYNC_W-1:0]    sync_2;
    logic [BUS_WIDTH-1:0] bus_in_s;
    logic                 read_s;
    logic                 register_select_s;
    logic                 enable_s;

    logic                 act;
    logic                 start;

    logic [ADDR_W-1:0]    address;
    logic [ADDR_W-1:0]    address_inc;
    logic [ADDR_W-1:0]    address_shift;
    logic [IDX_W-1:0]     index;
    logic [IDX_W-1:0]     eff_index;
    logic [IDX_W-1:0]     slot;
    logic                 last_rd;
    logic                 dir_flip;
    logic [MEM_W-1:0]     wbuf;
    logic                 commit;

    logic                 addr_beat;
    logic                 status_beat;
    logic                 wr_beat;
    logic                 rd_beat;

    logic [ADDRESS_DEPTH_LOG2-1:0] mem_addr;
    logic [MEM_W-1:0]              mem [DEPTH];
    logic [MEM_W-1:0]              rdata;

    // Two-flop synchronizers on every asynchronous host input
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {read, register_select, enable, bus_in};
            sync_2 <= sync_1;
        end
    end

    assign {read_s, register_select_s, enable_s, bus_in_s} = sync_2;

    // Handshake state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake next state: one beat per enable pulse
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable_s) state_d = S_ACT;
            S_ACT:   state_d = S_HOLD;
            S_HOLD:  if (!enable_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs and beat-phase strobes
    always_comb begin
        ack   = state_q[1];
        act   = (state_q == S_ACT);
        start = (state_q == S_IDLE) && enable_s;
    end

    assign bus_oe       = read_s & ack;
    assign write_strobe = commit;

    // Beat decode and word-position bookkeeping
    always_comb begin
        addr_beat     = !register_select_s && !read_s;
        status_beat   = !register_select_s &&  read_s;
        wr_beat       =  register_select_s && !read_s;
        rd_beat       =  register_select_s &&  read_s;
        dir_flip      = register_select_s && (read_s != last_rd);
        eff_index     = dir_flip ? '0 : index;
        slot          = LAST_IDX - eff_index;
        address_shift = (address << BUS_WIDTH) | ADDR_W'(bus_in_s);
        address_inc   = (address & ~LO_MASK)
                      | ((address + 1'b1) & LO_MASK);
        mem_addr      = address[ADDRESS_DEPTH_LOG2-1:0];
    end

    // Read and status data captured as the beat enters ACT, held until the next one
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus_out <= '0;
        end else if (start) begin
            if (status_beat) begin
                bus_out <= write_count;
            end else if (rd_beat) begin
                bus_out <= rdata[slot*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Beat processing in ACT, word commit on the following cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            address     <= '0;
            index       <= '0;
            last_rd     <= 1'b0;
            wbuf        <= '0;
            commit      <= 1'b0;
            write_count <= '0;
        end else if (commit) begin
            commit      <= 1'b0;
            write_count <= write_count + 1'b1;
            if (AUTO_INCREMENT) begin
                address <= address_inc;
            end
        end else if (act) begin
            unique case (1'b1)
                addr_beat: begin
                    address <= address_shift;
                    index   <= '0;
                end
                status_beat: begin
                end
                wr_beat: begin
                    last_rd <= 1'b0;
                    wbuf[slot*BUS_WIDTH +: BUS_WIDTH] <= bus_in_s;
                    if (eff_index == LAST_IDX) begin
                        index  <= '0;
                        commit <= 1'b1;
                    end else begin
                        index <= eff_index + 1'b1;
                    end
                end
                rd_beat: begin
                    last_rd <= 1'b1;
                    if (eff_index == LAST_IDX) begin
                        index <= '0;
                        if (AUTO_INCREMENT) begin
                            address <= address_inc;
                        end
                    end else begin
                        index <= eff_index + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shared-port RAM; contents survive reset, a reset cycle blocks a pending write
    always_ff @(posedge clock) begin
        if (commit && reset_n) begin
            mem[mem_addr] <= wbuf;
        end
        rdata <= mem[mem_addr];
    end

endmodule

// File: tb/tb_parallel_bus_pollable_memory.sv
// tb_parallel_bus_pollable_memory
// Directed and random host-bus beats against a word-level memory model.
module tb_parallel_bus_pollable_memory;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] bus_in = '0;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       read = 1'b0;
    logic       register_select = 1'b0;
    logic       enable = 1'b0;
    logic       ack;
    logic       write_strobe;
    logic [7:0] write_count;

    parallel_bus_pollable_memory dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .read            (read),
        .register_select (register_select),
        .enable          (enable),
        .ack             (ack),
        .write_strobe    (write_strobe),
        .write_count     (write_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int ack_rises = 0;
    logic ack_q = 1'b0;

    always @(negedge clock) begin
        if (write_strobe === 1'b1) strobe_cnt++;
        if (ack === 1'b1 && ack_q !== 1'b1) ack_rises++;
        ack_q = ack;
    end

    // word-level model
    logic [31:0] m_mem [256];
    bit          m_known [256];
    logic [15:0] m_addr;
    logic [7:0]  wq [$];
    int          rpos;
    bit          m_rd;
    int          m_wcount;
    int          m_writes;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0;
        wq.delete();
        rpos = 0;
        m_rd = 1'b0;
        m_wcount = 0;
    endtask

    task automatic beat(input logic rs, input logic rd, input logic [7:0] b,
                        input int hold, output logic [7:0] obs);
        int lat;
        @(negedge clock);
        register_select = rs;
        read = rd;
        bus_in = b;
        repeat (2) @(negedge clock);
        enable = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (ack === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("ack_rise_latency", lat, 3);
        obs = bus_out;
        chk("bus_oe_at_ack", {31'd0, bus_oe}, {31'd0, rd});
        repeat (hold - 3) @(negedge clock);
        enable = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (ack === 1'b0) begin
                lat = n;
                break;
            end
        end
        chk("ack_fall_latency", lat, 3);
        chk("bus_oe_idle", {31'd0, bus_oe}, 32'd0);
        @(negedge clock);
    endtask

    task automatic do_beat(input logic rs, input logic rd,
                           input logic [7:0] b, input int hold = 4);
        logic [7:0] obs;
        logic [7:0] a;
        beat(rs, rd, b, hold, obs);
        if (!rs && !rd) begin
            m_addr = {m_addr[7:0], b};
            wq.delete();
            rpos = 0;
        end else if (!rs && rd) begin
            chk("status", {24'd0, obs}, m_wcount);
        end else if (rs && !rd) begin
            if (m_rd) rpos = 0;
            m_rd = 1'b0;
            wq.push_back(b);
            if (wq.size() == 4) begin
                a = m_addr[7:0];
                m_mem[a] = {wq[0], wq[1], wq[2], wq[3]};
                m_known[a] = 1'b1;
                m_wcount = (m_wcount + 1) % 256;
                m_writes++;
                m_addr[7:0] = a + 8'd1;
                wq.delete();
            end
        end else begin
            if (!m_rd) wq.delete();
            m_rd = 1'b1;
            a = m_addr[7:0];
            if (m_known[a])
                chk("read_data", {24'd0, obs}, {24'd0, m_mem[a][8*(3-rpos) +: 8]});
            rpos++;
            if (rpos == 4) begin
                rpos = 0;
                m_addr[7:0] = a + 8'd1;
            end
        end
    endtask

    task automatic set_addr(input logic [15:0] a);
        do_beat(1'b0, 1'b0, a[15:8]);
        do_beat(1'b0, 1'b0, a[7:0]);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_strobes"}, strobe_cnt, m_writes);
        chk({tag, "_write_count"}, {24'd0, write_count}, m_wcount);
    endtask

    initial begin
        int r;
        int rises0;
        int strobes0;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
        model_reset();
        m_writes = 0;

        // reset state
        repeat (4) @(negedge clock);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
        chk("rst_write_strobe", {31'd0, write_strobe}, 32'd0);
        chk("rst_write_count", {24'd0, write_count}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // single word write then read back
        set_addr(16'h004C);
        do_beat(1'b1, 1'b0, 8'h01);
        do_beat(1'b1, 1'b0, 8'h23);
        do_beat(1'b1, 1'b0, 8'h2A);
        do_beat(1'b1, 1'b0, 8'h12);
        check_counts("single");
        set_addr(16'h004C);
        for (int i = 0; i < 4; i++) do_beat(1'b1, 1'b1, 8'h00);

        // burst across the address wrap
        set_addr(16'h00FF);
        for (int i = 0; i < 8; i++) do_beat(1'b1, 1'b0, 8'($urandom));
        check_counts("burst");
        set_addr(16'h00FF);
        for (int i = 0; i < 8; i++) do_beat(1'b1, 1'b1, 8'h00);

        // partial word discarded by an address beat
        set_addr(16'h0010);
        do_beat(1'b1, 1'b0, 8'h55);
        do_beat(1'b1, 1'b0, 8'h66);
        set_addr(16'h0010);
        do_beat(1'b1, 1'b0, 8'hAA);
        do_beat(1'b1, 1'b0, 8'hBB);
        do_beat(1'b1, 1'b0, 8'hCC);
        do_beat(1'b1, 1'b0, 8'hDD);
        check_counts("abort");
        set_addr(16'h0010);
        for (int i = 0; i < 4; i++) do_beat(1'b1, 1'b1, 8'h00);

        // long enable pulse gives one beat
        rises0 = ack_rises;
        do_beat(1'b0, 1'b1, 8'h00, 50);
        chk("long_enable_acks", ack_rises - rises0, 1);

        // reset in the middle of the final write beat
        set_addr(16'h0020);
        do_beat(1'b1, 1'b0, 8'h11);
        do_beat(1'b1, 1'b0, 8'h22);
        do_beat(1'b1, 1'b0, 8'h33);
        strobes0 = strobe_cnt;
        @(negedge clock);
        register_select = 1'b1;
        read = 1'b0;
        bus_in = 8'h44;
        repeat (2) @(negedge clock);
        enable = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        repeat (5) @(negedge clock);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("midrst_bus_out", {24'd0, bus_out}, 32'd0);
        chk("midrst_write_count", {24'd0, write_count}, 32'd0);
        enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clock);
        chk("midrst_no_write", strobe_cnt - strobes0, 0);

        // 256 word writes wrap the counter back to zero
        set_addr(16'h0000);
        for (int i = 0; i < 1024; i++) do_beat(1'b1, 1'b0, 8'($urandom));
        check_counts("wrap");
        do_beat(1'b0, 1'b1, 8'h00);

        // status beat inside a read word keeps the word position
        set_addr(16'h0005);
        do_beat(1'b1, 1'b1, 8'h00);
        do_beat(1'b1, 1'b1, 8'h00);
        do_beat(1'b0, 1'b1, 8'h00);
        do_beat(1'b1, 1'b1, 8'h00);
        do_beat(1'b1, 1'b1, 8'h00);

        // random mix of beat types, including read/write direction changes
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                do_beat(1'b0, 1'b0, 8'($urandom));
            else if (r == 1)
                do_beat(1'b0, 1'b1, 8'h00);
            else if (r < 6)
                do_beat(1'b1, 1'b0, 8'($urandom));
            else
                do_beat(1'b1, 1'b1, 8'h00);
        end
        check_counts("random");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
